// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - W-bit left/right shifter, one shift-amount bit per pipeline stage.
// Define PIPELINED_BARREL_SHIFTER_ARITH_EN to honour up_arith (arithmetic right shift).
module pipelined_barrel_shifter #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [W-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_valid,
    output logic [W-1:0]  down_data
);

`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
    localparam logic ARITH_EN = 1'b1;
`else
    localparam logic ARITH_EN = 1'b0;
`endif

    logic [SW-1:0]          valid_q;
    logic [SW-1:0]          dir_q;
    logic [SW-1:0]          arith_q;
    logic [SW-1:0]          msb_q;
    logic [SW-1:0][W-1:0]   data_q;
    logic [SW-1:0][SW-1:0]  shift_q;

    logic [SW-1:0]          in_valid;
    logic [SW-1:0]          in_dir;
    logic [SW-1:0]          in_arith;
    logic [SW-1:0]          in_msb;
    logic [SW-1:0][W-1:0]   in_data;
    logic [SW-1:0][SW-1:0]  in_shift;
    logic [SW-1:0][W-1:0]   shifted;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int AMT = 1 << k;
        logic fill;

        if (k == 0) begin : g_head
            assign in_valid[k] = up_valid;
            assign in_data[k]  = up_data;
            assign in_shift[k] = up_shift;
            assign in_dir[k]   = up_dir;
            assign in_arith[k] = up_arith;
            // The original operand MSB travels with the op so later stages fill correctly.
            assign in_msb[k]   = up_data[W-1];
        end else begin : g_body
            assign in_valid[k] = valid_q[k-1];
            assign in_data[k]  = data_q[k-1];
            assign in_shift[k] = shift_q[k-1];
            assign in_dir[k]   = dir_q[k-1];
            assign in_arith[k] = arith_q[k-1];
            assign in_msb[k]   = msb_q[k-1];
        end

        assign fill = ARITH_EN & in_dir[k] & in_arith[k] & in_msb[k];

        assign shifted[k] = !in_shift[k][k] ? in_data[k] :
                            in_dir[k]       ? {{AMT{fill}}, in_data[k][W-1:AMT]} :
                                              {in_data[k][W-1-AMT:0], {AMT{1'b0}}};
    end

    // Data is captured every cycle; only the valid bit distinguishes ops from bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            shift_q <= '0;
            dir_q   <= '0;
            arith_q <= '0;
            msb_q   <= '0;
        end else begin
            valid_q <= in_valid;
            data_q  <= shifted;
            shift_q <= in_shift;
            dir_q   <= in_dir;
            arith_q <= in_arith;
            msb_q   <= in_msb;
        end
    end

    assign down_valid = valid_q[SW-1];
    assign down_data  = data_q[SW-1];

    // Control carried into the last stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{dir_q[SW-1], arith_q[SW-1], msb_q[SW-1], shift_q[SW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - scoreboard bench for pipelined_barrel_shifter (W=8).
module tb_pipelined_barrel_shifter;
    localparam int W  = 8;
    localparam int SW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_valid = 1'b0;
    logic [W-1:0]  up_data = '0;
    logic [SW-1:0] up_shift = '0;
    logic          up_dir = 1'b0;
    logic          up_arith = 1'b0;
    logic          down_valid;
    logic [W-1:0]  down_data;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_shift   (up_shift),
        .up_dir     (up_dir),
        .up_arith   (up_arith),
        .down_valid (down_valid),
        .down_data  (down_data)
    );

    logic [W-1:0] exp_q[$];
    logic         vq[$];
    int           zero_left = 0;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;

`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
    localparam logic [W-1:0] EXP_B3_SRA3 = 8'b1111_0110;
    localparam logic [W-1:0] EXP_80_SRA7 = 8'hFF;
`else
    localparam logic [W-1:0] EXP_B3_SRA3 = 8'b0001_0110;
    localparam logic [W-1:0] EXP_80_SRA7 = 8'h01;
`endif

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s,
                                               input logic dir, input logic arith);
        logic ae;
`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
        ae = arith;
`else
        ae = 1'b0 & arith;
`endif
        if (!dir) return a << s;
        if (ae) return $signed(a) >>> s;
        return a >> s;
    endfunction

    // Reference timing: valid emerges SW edges after sampling; reset empties the pipe.
    always @(posedge clk) begin
        if (rst) begin
            vq.delete();
            for (int i = 0; i < SW; i++) vq.push_back(1'b0);
            exp_q.delete();
            zero_left = SW;
        end else begin
            vq.push_back(up_valid);
            void'(vq.pop_front());
            if (zero_left > 0) zero_left--;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (down_valid !== vq[0]) begin
                errors++;
                $display("FAIL valid t=%0t got %b want %b", $time, down_valid, vq[0]);
            end
            if (zero_left > 0) begin
                checks++;
                if (down_data !== '0) begin
                    errors++;
                    $display("FAIL reset_data t=%0t got %h want 00", $time, down_data);
                end
            end
            if (vq[0] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow t=%0t got %h want <nothing queued>", $time, down_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (down_valid === 1'b1) begin
                        checks++;
                        if (down_data !== e) begin
                            errors++;
                            $display("FAIL data t=%0t got %h want %h", $time, down_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] d, input logic [SW-1:0] s, input logic dir,
                         input logic ar, input logic [W-1:0] e);
        up_valid = 1'b1;
        up_data  = d;
        up_shift = s;
        up_dir   = dir;
        up_arith = ar;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        up_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            up_data  = W'($urandom);
            up_shift = SW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'h5A;
        up_shift = 3'd2;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        up_data = 8'hC3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        up_valid = 1'b0;
        idle(3);

        issue(8'b1011_0011, 3'd3, 1'b0, 1'b0, 8'b1001_1000);
        issue(8'b1011_0011, 3'd0, 1'b0, 1'b0, 8'b1011_0011);
        issue(8'b1011_0011, 3'd3, 1'b1, 1'b1, EXP_B3_SRA3);
        issue(8'b1011_0011, 3'd3, 1'b1, 1'b0, 8'b0001_0110);
        issue(8'b1011_0011, 3'd3, 1'b0, 1'b1, 8'b1001_1000);
        idle(1);
        issue(8'hFF, 3'd7, 1'b0, 1'b0, 8'h80);
        issue(8'hFF, 3'd7, 1'b1, 1'b0, 8'h01);
        issue(8'h80, 3'd7, 1'b1, 1'b1, EXP_80_SRA7);
        idle(4);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [W-1:0]  d;
                logic [SW-1:0] s;
                logic          dr;
                logic          ar;
                d  = W'($urandom);
                s  = SW'($urandom);
                dr = 1'($urandom);
                ar = 1'($urandom);
                issue(d, s, dr, ar, ref_shift(d, int'(s), dr, ar));
            end else begin
                idle(1);
            end
        end
        idle(4);

        // Two ops in flight, reset lands with the third; none may emerge.
        issue(8'h11, 3'd1, 1'b0, 1'b0, 8'h22);
        issue(8'h22, 3'd1, 1'b0, 1'b0, 8'h44);
        up_valid = 1'b1;
        up_data  = 8'h33;
        up_shift = 3'd1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        up_valid = 1'b0;
        issue(8'hA5, 3'd2, 1'b1, 1'b0, 8'h29);
        idle(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
